// File: rtl/lb_drp_arbiter.sv
// lb_drp_arbiter: round-robin arbiter that serialises several local-bus
// requesters onto a single DRP port, with a DRPRDY timeout so a hung DRP
// target reports an error instead of stalling every channel.
module lb_drp_arbiter #(
  parameter int C_CH_NUM     = 4,
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 16,
  parameter int C_TIMEOUT    = 1023
) (
  input  logic                             aclk,
  input  logic                             arst,
  input  logic [C_CH_NUM-1:0]              s_req,
  input  logic [C_CH_NUM-1:0]              s_we,
  input  logic [C_CH_NUM*C_ADDR_WIDTH-1:0] s_addr,
  input  logic [C_CH_NUM*C_DATA_WIDTH-1:0] s_wdata,
  output logic [C_CH_NUM-1:0]              s_ack,
  output logic [C_CH_NUM-1:0]              s_done,
  output logic [C_DATA_WIDTH-1:0]          s_rdata,
  output logic                             s_err,
  output logic                             busy,
  output logic [7:0]                       timeout_cnt,
  output logic                             drp_en,
  output logic                             drp_we,
  output logic [C_ADDR_WIDTH-1:0]          drp_addr,
  output logic [C_DATA_WIDTH-1:0]          drp_di,
  input  logic                             drp_rdy,
  input  logic [C_DATA_WIDTH-1:0]          drp_do
);

  localparam int PW = (C_CH_NUM > 1) ? $clog2(C_CH_NUM) : 1;
  localparam int TW = (C_TIMEOUT < 1) ? 1 : $clog2(C_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  state_e                  state_q;
  logic [PW-1:0]           ptr_q;
  logic [C_CH_NUM-1:0]     owner_q;
  logic                    we_q;
  logic [TW-1:0]           timer_q;
  logic [TW-1:0]           timer_inc;
  logic [C_CH_NUM-1:0]     s_ack_q;
  logic [C_CH_NUM-1:0]     s_done_q;
  logic [C_DATA_WIDTH-1:0] s_rdata_q;
  logic                    s_err_q;
  logic                    busy_q;
  logic [7:0]              tcnt_q;
  logic                    drp_en_q;
  logic                    drp_we_q;
  logic [C_ADDR_WIDTH-1:0] drp_addr_q;
  logic [C_DATA_WIDTH-1:0] drp_di_q;

  logic [C_ADDR_WIDTH-1:0] addr_arr  [C_CH_NUM];
  logic [C_DATA_WIDTH-1:0] wdata_arr [C_CH_NUM];

  logic                    sel_found;
  logic [PW-1:0]           sel_idx;
  logic [PW-1:0]           cand;
  logic [C_CH_NUM-1:0]     sel_oh;

  for (genvar gi = 0; gi < C_CH_NUM; gi++) begin : g_unpack
    assign addr_arr[gi]  = s_addr[gi*C_ADDR_WIDTH +: C_ADDR_WIDTH];
    assign wdata_arr[gi] = s_wdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  assign timer_inc = timer_q + 1'b1;

  // Round-robin search starting at ptr+1, wrapping past the last channel.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = ptr_q;
    sel_oh    = '0;
    for (int unsigned i = 0; i < C_CH_NUM; i++) begin
      cand = (cand == PW'(C_CH_NUM - 1)) ? '0 : cand + 1'b1;
      if (!sel_found && s_req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_oh[sel_idx] = 1'b1;
  end

  // Transaction FSM; every output is a flop written here.
  // The ISSUE-cycle outputs (drp_en, s_ack, addr/di) are loaded on the
  // IDLE->ISSUE edge so they are visible exactly during ISSUE. A grant is
  // withheld in the s_done cycle, giving requesters a cycle to drop s_req.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= PW'(C_CH_NUM - 1);
      owner_q    <= '0;
      we_q       <= 1'b0;
      timer_q    <= '0;
      s_ack_q    <= '0;
      s_done_q   <= '0;
      s_rdata_q  <= '0;
      s_err_q    <= 1'b0;
      busy_q     <= 1'b0;
      tcnt_q     <= '0;
      drp_en_q   <= 1'b0;
      drp_we_q   <= 1'b0;
      drp_addr_q <= '0;
      drp_di_q   <= '0;
    end else begin
      s_ack_q   <= '0;
      s_done_q  <= '0;
      s_rdata_q <= '0;
      s_err_q   <= 1'b0;
      drp_en_q  <= 1'b0;
      drp_we_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (sel_found && !(|s_done_q)) begin
            ptr_q      <= sel_idx;
            owner_q    <= sel_oh;
            we_q       <= s_we[sel_idx];
            drp_en_q   <= 1'b1;
            drp_we_q   <= s_we[sel_idx];
            drp_addr_q <= addr_arr[sel_idx];
            drp_di_q   <= wdata_arr[sel_idx];
            s_ack_q    <= sel_oh;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (drp_rdy) begin
            s_done_q  <= owner_q;
            s_rdata_q <= we_q ? '0 : drp_do;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else if ((C_TIMEOUT != 0) && (timer_inc == TW'(C_TIMEOUT))) begin
            s_done_q <= owner_q;
            s_err_q  <= 1'b1;
            if (tcnt_q != 8'hFF) begin
              tcnt_q <= tcnt_q + 8'd1;
            end
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_inc;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ack       = s_ack_q;
  assign s_done      = s_done_q;
  assign s_rdata     = s_rdata_q;
  assign s_err       = s_err_q;
  assign busy        = busy_q;
  assign timeout_cnt = tcnt_q;
  assign drp_en      = drp_en_q;
  assign drp_we      = drp_we_q;
  assign drp_addr    = drp_addr_q;
  assign drp_di      = drp_di_q;

endmodule

// File: tb/tb_lb_drp_arbiter.sv
// Testbench for lb_drp_arbiter: directed stimulus pushes expected DRP
// issues and completions into queues; a monitor pops and compares them.
module tb_lb_drp_arbiter;
  localparam int CH = 4;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            aclk = 1'b0;
  logic            arst;
  logic [CH-1:0]   s_req, s_we, s_ack, s_done;
  logic [CH*AW-1:0] s_addr;
  logic [CH*DW-1:0] s_wdata;
  logic [DW-1:0]   s_rdata;
  logic            s_err, busy;
  logic [7:0]      timeout_cnt;
  logic            drp_en, drp_we, drp_rdy;
  logic [AW-1:0]   drp_addr;
  logic [DW-1:0]   drp_di, drp_do;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int            cyc;
    logic [CH-1:0] oh;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
  } iss_t;

  typedef struct {
    int            cyc;
    logic [CH-1:0] oh;
    logic [DW-1:0] rdata;
    logic          err;
  } done_t;

  iss_t  iss_q[$];
  done_t done_q[$];

  lb_drp_arbiter #(
    .C_CH_NUM    (CH),
    .C_ADDR_WIDTH(AW),
    .C_DATA_WIDTH(DW),
    .C_TIMEOUT   (TO)
  ) dut (
    .aclk       (aclk),
    .arst       (arst),
    .s_req      (s_req),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_ack      (s_ack),
    .s_done     (s_done),
    .s_rdata    (s_rdata),
    .s_err      (s_err),
    .busy       (busy),
    .timeout_cnt(timeout_cnt),
    .drp_en     (drp_en),
    .drp_we     (drp_we),
    .drp_addr   (drp_addr),
    .drp_di     (drp_di),
    .drp_rdy    (drp_rdy),
    .drp_do     (drp_do)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_ch(input int ch, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
    s_we[ch]            = we;
    s_addr[ch*AW +: AW] = addr;
    s_wdata[ch*DW +: DW] = wdata;
    s_req[ch]           = 1'b1;
  endtask

  task automatic push_iss(input int c, input int ch, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] di);
    iss_t e;
    e.cyc = c; e.oh = '0; e.oh[ch] = 1'b1; e.we = we; e.addr = addr; e.di = di;
    iss_q.push_back(e);
  endtask

  task automatic push_done(input int c, input int ch, input logic [DW-1:0] rdata,
                           input logic err);
    done_t e;
    e.cyc = c; e.oh = '0; e.oh[ch] = 1'b1; e.rdata = rdata; e.err = err;
    done_q.push_back(e);
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_busy"},  32'(busy), 0);
    check({p, "_en"},    32'(drp_en), 0);
    check({p, "_we"},    32'(drp_we), 0);
    check({p, "_addr"},  32'(drp_addr), 0);
    check({p, "_di"},    32'(drp_di), 0);
    check({p, "_ack"},   32'(s_ack), 0);
    check({p, "_done"},  32'(s_done), 0);
    check({p, "_rdata"}, 32'(s_rdata), 0);
    check({p, "_err"},   32'(s_err), 0);
    check({p, "_tcnt"},  32'(timeout_cnt), 0);
  endtask

  // Monitor: compare every DRP issue and every completion against the queues.
  always @(negedge aclk) begin
    iss_t  ie;
    done_t de;
    if (drp_en) begin
      if (iss_q.size() == 0) begin
        check("en_unexpected", 32'(drp_en), 0);
      end else begin
        ie = iss_q.pop_front();
        check("en_cycle", cyc, ie.cyc);
        check("en_ack",   32'(s_ack), 32'(ie.oh));
        check("en_we",    32'(drp_we), 32'(ie.we));
        check("en_addr",  32'(drp_addr), 32'(ie.addr));
        check("en_di",    32'(drp_di), 32'(ie.di));
        check("en_busy",  32'(busy), 1);
      end
    end else begin
      check("idle_we_ack", 32'({drp_we, s_ack}), 0);
    end
    if (|s_done) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 32'(s_done), 0);
      end else begin
        de = done_q.pop_front();
        check("done_cycle", cyc, de.cyc);
        check("done_ch",    32'(s_done), 32'(de.oh));
        check("done_rdata", 32'(s_rdata), 32'(de.rdata));
        check("done_err",   32'(s_err), 32'(de.err));
        check("done_busy",  32'(busy), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [CH-1:0] wep;
    arst = 1'b1; s_req = '0; s_we = '0; s_addr = '0; s_wdata = '0;
    drp_rdy = 1'b0; drp_do = '0;
    repeat (3) tick();
    check_all_zero("rst");
    arst = 1'b0;
    repeat (2) tick();

    // Single read on ch0, DRPRDY at cycle 3.
    t0 = cyc;
    set_ch(0, 1'b0, 12'h012, 16'h5A5A);
    push_iss(t0 + 1, 0, 1'b0, 12'h012, 16'h5A5A);
    push_done(t0 + 4, 0, 16'hBEEF, 1'b0);
    tick(); s_req = '0;
    wait_until(t0 + 3); drp_rdy = 1'b1; drp_do = 16'hBEEF;
    tick(); drp_rdy = 1'b0; drp_do = '0;
    wait_until(t0 + 5);
    check("hold_addr", 32'(drp_addr), 32'h012);
    check("hold_di", 32'(drp_di), 32'h5A5A);
    tick();

    // Write on ch2, DRPRDY at cycle 2 (minimum turnaround).
    t0 = cyc;
    set_ch(2, 1'b1, 12'h0A5, 16'h1234);
    push_iss(t0 + 1, 2, 1'b1, 12'h0A5, 16'h1234);
    push_done(t0 + 3, 2, 16'h0000, 1'b0);
    tick(); s_req = '0;
    wait_until(t0 + 2); drp_rdy = 1'b1; drp_do = 16'hDEAD;
    tick(); drp_rdy = 1'b0; drp_do = '0;
    repeat (3) tick();

    // Timeout on ch1, no DRPRDY: error completion at cycle 2+TO.
    t0 = cyc;
    set_ch(1, 1'b0, 12'h3C0, 16'h0000);
    push_iss(t0 + 1, 1, 1'b0, 12'h3C0, 16'h0000);
    push_done(t0 + 2 + TO, 1, 16'h0000, 1'b1);
    tick(); s_req = '0;
    wait_until(t0 + 1 + TO);
    check("to_busy_last", 32'(busy), 1);
    check("to_cnt_before", 32'(timeout_cnt), 0);
    tick();
    check("to_cnt_after", 32'(timeout_cnt), 1);
    repeat (3) tick();

    // DRPRDY on the very cycle the timer reaches TO: normal completion.
    t0 = cyc;
    set_ch(3, 1'b0, 12'h7FF, 16'hFFFF);
    push_iss(t0 + 1, 3, 1'b0, 12'h7FF, 16'hFFFF);
    push_done(t0 + 2 + TO, 3, 16'h0F0F, 1'b0);
    tick(); s_req = '0;
    wait_until(t0 + 1 + TO); drp_rdy = 1'b1; drp_do = 16'h0F0F;
    tick(); drp_rdy = 1'b0; drp_do = '0;
    tick();
    check("race_cnt", 32'(timeout_cnt), 1);
    repeat (2) tick();

    // 300 back-to-back timeouts on ch0 saturate the counter.
    t0 = cyc;
    set_ch(0, 1'b1, 12'h001, 16'hCAFE);
    for (int j = 0; j < 300; j++) begin
      push_iss(t0 + 1 + 11*j, 0, 1'b1, 12'h001, 16'hCAFE);
      push_done(t0 + 10 + 11*j, 0, 16'h0000, 1'b1);
    end
    wait_until(t0 + 11*299 + 1); s_req = '0;
    wait_until(t0 + 11*299 + 12);
    check("sat_cnt", 32'(timeout_cnt), 255);
    check("sat_busy", 32'(busy), 0);
    tick();

    // Reset during WAIT; a late DRPRDY must not produce a completion.
    t0 = cyc;
    set_ch(2, 1'b0, 12'h055, 16'h7777);
    push_iss(t0 + 1, 2, 1'b0, 12'h055, 16'h7777);
    tick(); s_req = '0;
    wait_until(t0 + 3);
    check("pre_rst_busy", 32'(busy), 1);
    arst = 1'b1;
    tick();
    check_all_zero("mid_rst");
    tick(); arst = 1'b0;
    wait_until(t0 + 7); drp_rdy = 1'b1; drp_do = 16'h1111;
    tick(); drp_rdy = 1'b0; drp_do = '0;
    repeat (3) tick();
    check("post_rst_busy", 32'(busy), 0);

    // All channels requesting continuously: grants 0,1,2,3,0,1,2,3.
    t0 = cyc;
    wep = 4'b1010;
    for (int c = 0; c < CH; c++) begin
      set_ch(c, wep[c], 12'(12'h100 + c), 16'(16'h1111 * (c + 1)));
    end
    for (int j = 0; j < 8; j++) begin
      int c;
      c = j % CH;
      push_iss(t0 + 1 + 4*j, c, wep[c], 12'(12'h100 + c), 16'(16'h1111 * (c + 1)));
      push_done(t0 + 3 + 4*j, c, wep[c] ? 16'h0000 : 16'(16'hA000 + j), 1'b0);
    end
    for (int j = 0; j < 8; j++) begin
      if (j == 7) begin
        wait_until(t0 + 29); s_req = '0;
      end
      wait_until(t0 + 2 + 4*j); drp_rdy = 1'b1; drp_do = 16'(16'hA000 + j);
      tick(); drp_rdy = 1'b0; drp_do = '0;
    end
    repeat (6) tick();

    check("iss_q_empty", 32'(iss_q.size()), 0);
    check("done_q_empty", 32'(done_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
